// File: rtl/mem_arbiter.sv
// Two-port req/ack arbiter and access sequencer for a single-ported memory (async read, sync write).
// Define MEM_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority with port 1 winning.
module mem_arbiter #(
    parameter int DATAWIDTH = 16,
    parameter int ADDRWIDTH = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 we0,
    input  logic [ADDRWIDTH-1:0] addr0,
    input  logic [DATAWIDTH-1:0] wdata0,
    output logic                 ack0,
    output logic [DATAWIDTH-1:0] rdata0,
    input  logic                 req1,
    input  logic                 we1,
    input  logic [ADDRWIDTH-1:0] addr1,
    input  logic [DATAWIDTH-1:0] wdata1,
    output logic                 ack1,
    output logic [DATAWIDTH-1:0] rdata1,
    output logic [ADDRWIDTH-1:0] mem_addr,
    output logic [DATAWIDTH-1:0] mem_wdata,
    output logic                 mem_write_n,
    output logic                 mem_enable_n,
    input  logic [DATAWIDTH-1:0] mem_rdata,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t state;
    logic   grant;
    logic   gwe;
    logic   win;

`ifdef MEM_ARB_RR_EN
    logic last;

    // On a tie the port that was not granted last time wins.
    always_comb begin
        win = req1;
        if (req0 && req1) begin
            win = ~last;
        end
    end
`else
    always_comb win = req1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            busy         <= 1'b0;
            rdata0       <= '0;
            rdata1       <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_write_n  <= 1'b1;
            mem_enable_n <= 1'b1;
            grant        <= 1'b0;
            gwe          <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last         <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        state <= ACCESS;
                        busy  <= 1'b1;
                        grant <= win;
`ifdef MEM_ARB_RR_EN
                        last  <= win;
`endif
                        if (win) begin
                            mem_addr     <= addr1;
                            mem_wdata    <= wdata1;
                            gwe          <= we1;
                            mem_write_n  <= ~we1;
                            mem_enable_n <= we1;
                        end else begin
                            mem_addr     <= addr0;
                            mem_wdata    <= wdata0;
                            gwe          <= we0;
                            mem_write_n  <= ~we0;
                            mem_enable_n <= we0;
                        end
                    end
                end
                ACCESS: begin
                    // Read data is captured on the same edge the write commits and the strobes release.
                    state        <= DONE;
                    mem_write_n  <= 1'b1;
                    mem_enable_n <= 1'b1;
                    if (grant) begin
                        ack1 <= 1'b1;
                        if (!gwe) begin
                            rdata1 <= mem_rdata;
                        end
                    end else begin
                        ack0 <= 1'b1;
                        if (!gwe) begin
                            rdata0 <= mem_rdata;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-ported `memory` block: 16-bit data, active-low write strobe, active-low output enable, asynchronous read, synchronous write.
- Shares the memory between the instruction-fetch port (port 0) and the load/store port (port 1).
- Provides a req/ack handshake per port and registers all memory control and address signals.
- Captures read data, then returns it with the ack.

Parameters:
- DATAWIDTH, 16, data word width; must match the memory.
- ADDRWIDTH, 20, address width; must match the memory.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  port 0 request; held high until ack0.
- we0  input  1  port 0 write (1) / read (0); stable while req0 is high.
- addr0  input  ADDRWIDTH  port 0 address; stable while req0 is high.
- wdata0  input  DATAWIDTH  port 0 write data.
- ack0  output  1  one-cycle pulse: port 0 access complete.
- rdata0  output  DATAWIDTH  port 0 read data; valid while ack0 is high.
- req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1.
- mem_addr  output  ADDRWIDTH  memory address.
- mem_wdata  output  DATAWIDTH  memory write data.
- mem_write_n  output  1  memory write strobe, active low.
- mem_enable_n  output  1  memory output enable, active low.
- mem_rdata  input  DATAWIDTH  memory read data.
- busy  output  1  high when the FSM is not in IDLE.

Behaviour:
- FSM states: IDLE, ACCESS, DONE. All outputs are registered.
- Reset values:
  - state = IDLE.
  - ack0, ack1 = 0; busy = 0.
  - rdata0, rdata1, mem_addr, mem_wdata = 0.
  - mem_write_n = 1; mem_enable_n = 1.
  - last-granted pointer = port 1, so port 0 wins the first tie.
- IDLE:
  - No request: stay in IDLE.
  - Any request: pick a winner (see priority), then go to ACCESS.
  - On the same edge, load the winner's address into mem_addr and its write data into mem_wdata, and register the grant index and the winner's we.
  - If the winner is a write, drive mem_write_n = 0; if a read, drive mem_enable_n = 0.
- ACCESS, exactly one cycle:
  - Memory control is asserted for the whole cycle.
  - A write commits in the memory at the edge that ends ACCESS.
  - For a read, mem_rdata is captured at that edge into the granted port's rdata register.
  - Then go to DONE, deasserting mem_write_n and mem_enable_n (both back to 1).
- DONE, exactly one cycle:
  - Pulse ack of the granted port for this cycle only.
  - rdataN holds its value until that port's next read.
  - Always return to IDLE. A req still high in the DONE cycle is not arbitrated until IDLE.
- Latency:
  - Request seen in IDLE at edge N: ACCESS = cycle N+1, ack = cycle N+2.
  - One access every 3 cycles at most.
  - A requester that keeps req high after ack starts a new access (back-to-back).
- Priority without the feature: fixed. Port 1 (load/store) wins a simultaneous request.
- Simultaneous requests: the loser keeps req high and is served in the next IDLE.
- Read-after-write on the same address, across two accesses, returns the new data.
- Only the granted port's ack and rdata change.
- busy = 1 in ACCESS and DONE.
- Reset mid-operation:
  - rst wins at the next edge; the FSM goes to IDLE and all outputs take their reset values.
  - A write whose ACCESS cycle is current when rst is sampled still commits, because the memory samples the registered strobe at that same edge.
  - No ack is issued for an aborted access.
- Inputs of a non-granted port are ignored; changing them while its req is high is illegal.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit last-granted pointer updates on every grant.
  - On simultaneous requests, the port not last granted wins.
  - This guarantees no starvation: a port waits at most one access.
- MEM_ARB_RR_EN undefined:
  - Fixed priority, port 1 over port 0.
  - The pointer logic is absent.
  - Port 0 can starve under a continuous port 1 stream.

Test Plan:
- Reset, then idle:
  - rst = 1 for 2 cycles → mem_write_n = 1, mem_enable_n = 1, ack0/ack1 = 0, busy = 0, rdata0/rdata1 = 0.
- Single write then read:
  - Port 0 write, addr = 0x00010, data = 0xBEEF → mem_write_n low exactly 1 cycle, ack0 pulses 2 cycles after req.
  - Then port 0 read of 0x00010 → ack0 with rdata0 = 0xBEEF; mem_enable_n low exactly 1 cycle.
- Conflict:
  - Same cycle: req0 = read 0x00020, req1 = write 0x00020, data 0x1234.
  - Without MEM_ARB_RR_EN: ack1 first; ack0 three cycles later with rdata0 = 0x1234.
- Round-robin (MEM_ARB_RR_EN defined):
  - req0 and req1 both held high for 12 cycles → acks alternate 0, 1, 0, 1, spaced 3 cycles apart.
- Starvation (MEM_ARB_RR_EN undefined):
  - Same stimulus as the round-robin scenario → only ack1 pulses; ack0 = 0 throughout.
- Reset mid-write:
  - rst asserted in the ACCESS cycle of a port 1 write of 0xCAFE to 0x00030 → no ack1; FSM in IDLE.
  - A following port 0 read of 0x00030 returns 0xCAFE.
